// File: rtl/nubus_pkg.sv
// Shared NuBus definitions: start-mode codes, ack status codes, the
// responder state encoding and the byte-lane strobe map.
package nubus_pkg;

  // Start-cycle transfer modes, true polarity {tm1, tm0, a1, a0}.
  typedef enum logic [3:0] {
    WR_BYTE_3 = 4'b0000,
    WR_BYTE_2 = 4'b0001,
    WR_BYTE_1 = 4'b0010,
    WR_BYTE_0 = 4'b0011,
    WR_HALF_1 = 4'b0100,
    WR_BLOCK  = 4'b0101,
    WR_HALF_0 = 4'b0110,
    WR_WORD   = 4'b0111,
    RD_BYTE_3 = 4'b1000,
    RD_BYTE_2 = 4'b1001,
    RD_BYTE_1 = 4'b1010,
    RD_BYTE_0 = 4'b1011,
    RD_HALF_1 = 4'b1100,
    RD_BLOCK  = 4'b1101,
    RD_HALF_0 = 4'b1110,
    RD_WORD   = 4'b1111
  } start_mode_e;

  // Ack status, true polarity {tm1, tm0}.
  typedef enum logic [1:0] {
    ST_COMPLETE  = 2'b00,
    ST_ERROR     = 2'b01,
    ST_TIMEOUT   = 2'b10,
    ST_TRY_AGAIN = 2'b11
  } ack_status_e;

  // Responder state machine.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DATA = 2'b01,
    S_MEM  = 2'b10,
    S_ACK  = 2'b11
  } slave_state_e;

  // Byte-lane strobes for the low three mode bits; bit i covers AD[8i+7:8i].
  // The block code (101) maps to no lanes.
  function automatic logic [3:0] lane_strobes(input logic [2:0] m);
    logic [3:0] s;
    case (m)
      3'b000:  s = 4'b1000;
      3'b001:  s = 4'b0100;
      3'b010:  s = 4'b0010;
      3'b011:  s = 4'b0001;
      3'b100:  s = 4'b1100;
      3'b110:  s = 4'b0011;
      3'b111:  s = 4'b1111;
      default: s = 4'b0000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/nubus_slave_decoder.sv
// Combinational start-cycle decode: address/ID hit and transfer-mode
// translation into byte strobes, read flag and block flag.
module nubus_slave_decoder
  import nubus_pkg::*;
#(
  parameter bit SUPERSLOT_EN = 1'b1
) (
  input  logic [3:0] mode,      // {tm1, tm0, a1, a0}, true polarity
  input  logic [7:0] addr_hi,   // address bits [31:24], true polarity
  input  logic [3:0] id,        // slot ID, true polarity
  output logic       hit,
  output logic       slot_hit,
  output logic       super_hit,
  output logic [3:0] strobes,
  output logic       read,
  output logic       block
);

  // Address match and mode translation; reads carry no strobes.
  always_comb begin
    slot_hit  = (addr_hi == {4'hF, id});
    super_hit = SUPERSLOT_EN && (addr_hi[7:4] == id) &&
                (id != 4'h0) && (id != 4'hF);
    hit       = slot_hit | super_hit;
    read      = mode[3];
    block     = (mode[2:0] == 3'b101);
    strobes   = read ? 4'b0000 : lane_strobes(mode[2:0]);
  end

endmodule

// File: rtl/nubus_slave.sv
// NuBus responder front end. Turns each decoded START hit into one
// single-beat mem_* transaction and answers the master with /ACK and status.
//
// mem_* handshake: mem_valid rises the cycle after the data cycle and holds,
// with mem_addr/mem_write/mem_wdata/mem_slot/mem_super stable, until the
// clock edge at which mem_ready is sampled high (or the watchdog expires);
// a transfer completes on that edge and mem_rdata is captured there.
module nubus_slave
  import nubus_pkg::*;
#(
  parameter int WDT_W        = 3,
  parameter bit SUPERSLOT_EN = 1'b1
) (
  input  logic        nub_clk,
  input  logic        nub_reset,
  input  logic [3:0]  nub_idn,
  input  logic        nub_startn,
  input  logic        nub_ackn_i,
  input  logic        nub_tm0n_i,
  input  logic        nub_tm1n_i,
  input  logic [31:0] nub_adn_i,
  output logic        nub_ackn_o,
  output logic        nub_ack_oe,
  output logic        nub_tm0n_o,
  output logic        nub_tm1n_o,
  output logic [31:0] nub_adn_o,
  output logic        nub_ad_oe,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [3:0]  mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        mem_slot,
  output logic        mem_super,
  output logic [1:0]  dbg_state
);

  slave_state_e     state;
  logic [WDT_W-1:0] wdt;
  logic             rd_q;
  logic             blk_q;

  logic [31:0] addr_t;
  logic [3:0]  mode_t;
  logic [3:0]  id_t;
  logic        dec_hit;
  logic        dec_slot;
  logic        dec_super;
  logic [3:0]  dec_strobes;
  logic        dec_read;
  logic        dec_block;
  logic        start_hit;

  localparam logic [WDT_W-1:0] WDT_ONE = {{(WDT_W-1){1'b0}}, 1'b1};

  assign addr_t    = ~nub_adn_i;
  assign mode_t    = {~nub_tm1n_i, ~nub_tm0n_i, addr_t[1:0]};
  assign id_t      = ~nub_idn;
  // An attention cycle (START with /ACK low) is never a transaction.
  assign start_hit = ~nub_startn & nub_ackn_i & dec_hit;
  assign dbg_state = state;

  nubus_slave_decoder #(
    .SUPERSLOT_EN (SUPERSLOT_EN)
  ) u_decoder (
    .mode      (mode_t),
    .addr_hi   (addr_t[31:24]),
    .id        (id_t),
    .hit       (dec_hit),
    .slot_hit  (dec_slot),
    .super_hit (dec_super),
    .strobes   (dec_strobes),
    .read      (dec_read),
    .block     (dec_block)
  );

  // Responder FSM with registered bus and memory-side outputs.
  always_ff @(posedge nub_clk or posedge nub_reset) begin
    if (nub_reset) begin
      state      <= S_IDLE;
      wdt        <= '0;
      rd_q       <= 1'b0;
      blk_q      <= 1'b0;
      mem_valid  <= 1'b0;
      mem_write  <= 4'b0000;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_slot   <= 1'b0;
      mem_super  <= 1'b0;
      nub_ack_oe <= 1'b0;
      nub_ackn_o <= 1'b1;
      nub_tm1n_o <= 1'b1;
      nub_tm0n_o <= 1'b1;
      nub_adn_o  <= '1;
      nub_ad_oe  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_hit) begin
            mem_addr  <= {addr_t[31:2], 2'b00};
            mem_write <= dec_strobes;
            rd_q      <= dec_read;
            blk_q     <= dec_block;
            mem_slot  <= dec_slot;
            mem_super <= dec_super;
            state     <= S_DATA;
          end
        end
        S_DATA: begin
          mem_wdata <= ~nub_adn_i;
          if (blk_q) begin
            // Block transfers are refused without touching memory.
            nub_ack_oe               <= 1'b1;
            nub_ackn_o               <= 1'b0;
            {nub_tm1n_o, nub_tm0n_o} <= ~ST_ERROR;
            state                    <= S_ACK;
          end else begin
            mem_valid <= 1'b1;
            wdt       <= '0;
            state     <= S_MEM;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            mem_valid                <= 1'b0;
            nub_ack_oe               <= 1'b1;
            nub_ackn_o               <= 1'b0;
            {nub_tm1n_o, nub_tm0n_o} <= ~ST_COMPLETE;
            if (rd_q) begin
              nub_adn_o <= ~mem_rdata;
              nub_ad_oe <= 1'b1;
            end
            state <= S_ACK;
          end else if (wdt == '1) begin
            mem_valid                <= 1'b0;
            nub_ack_oe               <= 1'b1;
            nub_ackn_o               <= 1'b0;
            {nub_tm1n_o, nub_tm0n_o} <= ~ST_ERROR;
            state                    <= S_ACK;
          end else begin
            wdt <= wdt + WDT_ONE;
          end
        end
        S_ACK: begin
          // Ack lasts exactly one clock, then release all drivers.
          nub_ack_oe <= 1'b0;
          nub_ackn_o <= 1'b1;
          nub_tm1n_o <= 1'b1;
          nub_tm0n_o <= 1'b1;
          nub_adn_o  <= '1;
          nub_ad_oe  <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
